// File: rtl/bmem_responder.sv
// Memory-side responder for the burst-memory (bmem) port: stores 256-bit lines as four
// 64-bit words and returns read data as in-order 4-beat bursts after a fixed latency.
module bmem_responder #(
  parameter int ADDR_LINES   = 256,
  parameter int READ_LATENCY = 8,
  parameter int QUEUE_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] bmem_addr,
  input  logic        bmem_read,
  input  logic        bmem_write,
  input  logic [63:0] bmem_wdata,
  output logic        bmem_ready,
  output logic [31:0] bmem_raddr,
  output logic [63:0] bmem_rdata,
  output logic        bmem_rvalid,
  output logic        bmem_err
);

  localparam int IDX_W = $clog2(ADDR_LINES);
  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam logic [PTR_W:0]   DEPTH_C = (PTR_W+1)'(QUEUE_DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [7:0]       RL_SAT  = 8'(READ_LATENCY);
  localparam logic [7:0]       RL_DUE  = 8'(READ_LATENCY - 1);

  typedef enum logic {W_IDLE, W_BURST} wstate_e;
  typedef enum logic {R_IDLE, R_BURST} rstate_e;

  logic [63:0] mem [ADDR_LINES*4];

  wstate_e            wstate_q, wstate_d;
  logic [1:0]         wbeat_q, wbeat_d;
  logic [IDX_W-1:0]   wline_q, wline_d;
  logic               held_rd_q, held_rd_d;
  logic               err_q, err_d;
  logic               ready_en_q;

  logic [26:0]        qline_q [QUEUE_DEPTH];
  logic [26:0]        qline_d [QUEUE_DEPTH];
  logic [7:0]         age_q [QUEUE_DEPTH];
  logic [7:0]         age_d [QUEUE_DEPTH];
  logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
  logic [PTR_W:0]     count_q, count_d;

  rstate_e            rstate_q, rstate_d;
  logic [1:0]         rbeat_q, rbeat_d;
  logic               rvalid_q, rvalid_d;
  logic [63:0]        rdata_q, rdata_d;
  logic [26:0]        raddr_q, raddr_d;

  logic               mem_we;
  logic [IDX_W+1:0]   mem_waddr;
  logic [63:0]        mem_wdata;
  logic               wr_accept, rd_accept, head_due, emit, pop;
  logic [1:0]         emit_beat;
  logic [26:0]        head_line;
  logic [IDX_W-1:0]   addr_idx;
  logic               unused_addr_bits;

  assign unused_addr_bits = ^bmem_addr[4:0];
  assign addr_idx  = bmem_addr[5 +: IDX_W];

  // Ready is a function of registered state only; ready_en_q holds it low through reset.
  assign bmem_ready = ready_en_q && ((wstate_q == W_BURST) || (count_q < DEPTH_C));
  assign wr_accept  = bmem_ready && (wstate_q == W_IDLE) && bmem_write;
  assign rd_accept  = bmem_ready && (wstate_q == W_IDLE) && bmem_read && !bmem_write;

  // A read raised together with the write that opened the burst is being held by the
  // initiator, so it is not a protocol error while the burst runs.
  always_comb begin
    wstate_d  = wstate_q;
    wbeat_d   = wbeat_q;
    wline_d   = wline_q;
    held_rd_d = held_rd_q;
    err_d     = err_q;
    mem_we    = 1'b0;
    mem_waddr = {wline_q, wbeat_q};
    mem_wdata = bmem_wdata;
    case (wstate_q)
      W_IDLE: begin
        if (wr_accept) begin
          mem_we    = 1'b1;
          mem_waddr = {addr_idx, 2'd0};
          wline_d   = addr_idx;
          wbeat_d   = 2'd1;
          held_rd_d = bmem_read;
          wstate_d  = W_BURST;
        end
      end
      W_BURST: begin
        if (bmem_read && !held_rd_q) err_d = 1'b1;
        held_rd_d = held_rd_q && bmem_read;
        if (bmem_write) begin
          mem_we  = 1'b1;
          wbeat_d = wbeat_q + 2'd1;
          if (wbeat_q == 2'd3) wstate_d = W_IDLE;
        end else begin
          err_d    = 1'b1;
          wstate_d = W_IDLE;
        end
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign head_line = qline_q[head_q];
  assign head_due  = (count_q != '0) && (age_q[head_q] >= RL_DUE);

  // Back-to-back bursts: after beat 3 the idle state relaunches on the very next edge
  // when the new head is due, so consecutive bursts leave no gap.
  always_comb begin
    rstate_d  = rstate_q;
    rbeat_d   = rbeat_q;
    emit      = 1'b0;
    emit_beat = rbeat_q;
    pop       = 1'b0;
    case (rstate_q)
      R_IDLE: begin
        if (head_due) begin
          emit      = 1'b1;
          emit_beat = 2'd0;
          rbeat_d   = 2'd1;
          rstate_d  = R_BURST;
        end
      end
      R_BURST: begin
        emit    = 1'b1;
        rbeat_d = rbeat_q + 2'd1;
        if (rbeat_q == 2'd3) begin
          pop      = 1'b1;
          rstate_d = R_IDLE;
        end
      end
      default: rstate_d = R_IDLE;
    endcase
    rvalid_d = emit;
    rdata_d  = emit ? mem[{head_line[IDX_W-1:0], emit_beat}] : rdata_q;
    raddr_d  = emit ? head_line : raddr_q;
  end

  always_comb begin
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      qline_d[i] = qline_q[i];
      age_d[i]   = (age_q[i] >= RL_SAT) ? RL_SAT : age_q[i] + 8'd1;
    end
    tail_d = tail_q;
    if (rd_accept) begin
      qline_d[tail_q] = bmem_addr[31:5];
      age_d[tail_q]   = 8'd0;
      tail_d          = tail_q + PTR_ONE;
    end
    head_d = pop ? head_q + PTR_ONE : head_q;
    case ({rd_accept, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wstate_q   <= W_IDLE;
      wbeat_q    <= 2'd0;
      wline_q    <= '0;
      held_rd_q  <= 1'b0;
      err_q      <= 1'b0;
      ready_en_q <= 1'b0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        qline_q[i] <= '0;
        age_q[i]   <= '0;
      end
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      rstate_q   <= R_IDLE;
      rbeat_q    <= 2'd0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      raddr_q    <= '0;
    end else begin
      wstate_q   <= wstate_d;
      wbeat_q    <= wbeat_d;
      wline_q    <= wline_d;
      held_rd_q  <= held_rd_d;
      err_q      <= err_d;
      ready_en_q <= 1'b1;
      qline_q    <= qline_d;
      age_q      <= age_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      rstate_q   <= rstate_d;
      rbeat_q    <= rbeat_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      raddr_q    <= raddr_d;
    end
  end

  assign bmem_rvalid = rvalid_q;
  assign bmem_rdata  = rdata_q;
  assign bmem_raddr  = {raddr_q, 5'b0};
  assign bmem_err    = err_q;

endmodule

// File: doc/bmem_responder.md
# bmem_responder

Synthesizable responder for the CPU's burst-memory (bmem) port: the memory-side end of the protocol driven by the cacheline adapter. Accepts line reads and 4-beat line writes, stores 256-bit lines as four 64-bit words, and returns read data as in-order 4-beat bursts after a programmable latency. It is used as the on-chip backing memory in FPGA builds and as the reference responder in cache and adapter benches.

## Interface
- ADDR_LINES, 256, number of 32-byte lines stored; line index = bmem_addr[31:5] mod ADDR_LINES (power of two).
- READ_LATENCY, 8, cycles from read accept to first rvalid beat; legal range 2..255.
- QUEUE_DEPTH, 4, outstanding read requests held; power of two, 2..16.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- bmem_addr  in  32  request byte address; bits [4:0] ignored.
- bmem_read  in  1  read request.
- bmem_write  in  1  write request; held high for all 4 beats.
- bmem_wdata  in  64  write beat data.
- bmem_ready  out  1  request/beat accepted this cycle when high.
- bmem_raddr  out  32  line address of the returning burst, bits [4:0] = 0.
- bmem_rdata  out  64  read beat data.
- bmem_rvalid  out  1  read beat valid.
- bmem_err  out  1  sticky protocol-error flag.

## Operation
- Accept: request accepted on an edge where bmem_ready=1 and (bmem_read or bmem_write).
- Read and write both high on an idle cycle: write accepted, read not accepted (initiator must hold it); bmem_err not set.
- Write FSM: W_IDLE -> W_BURST on accepted write (beat 0 stored to word 0, line latched from bmem_addr). In W_BURST, beat counter 1..3; each cycle bmem_write=1 stores bmem_wdata to word k; after beat 3 -> W_IDLE.
- bmem_write low during W_BURST: set bmem_err, abort burst (beats already stored remain), -> W_IDLE.
- bmem_read high during W_BURST: set bmem_err, read not accepted.
- Read queue: FIFO of {line address, age counter}. Accepted read pushed with age 0; every entry's age increments each cycle, saturating at READ_LATENCY.
- Response FSM: R_IDLE -> R_BURST when head entry age = READ_LATENCY; emits beats 0..3 on 4 consecutive cycles, pops the entry on beat 3. If next head is also due, R_BURST continues with no gap.
- Read data: each beat reads the array in the cycle it is emitted; a write whose final beat completes before the first read beat is fully visible.
- bmem_ready = (write FSM in W_BURST) or (queue count < QUEUE_DEPTH). Count is current-state only; a pop in the same cycle does not free a slot for acceptance.
- Array contents not reset.

## Timing
- Reset (async assert): bmem_ready=0, bmem_rvalid=0, bmem_rdata=0, bmem_raddr=0, bmem_err=0, queue empty, both FSMs idle. In-flight bursts are dropped with no further beats. bmem_ready rises the first cycle after rst deasserts.
- Read accepted at edge T: beat 0 at cycle T+READ_LATENCY when response port idle; beats 1..3 at following cycles.
- Back-to-back reads accepted at T and T+1: second burst beat 0 at T+READ_LATENCY+4 (port-limited).
- Write: 4 cycles, ready=1 throughout; next request accepted at cycle 5 earliest.
- Outputs bmem_rvalid/rdata/raddr registered; bmem_ready combinational from state only (no input dependence).
- Queue full with a pop in the same cycle: bmem_ready=0 that cycle, 1 the next.

## Test plan
- Write line 0x0000_0040 with beats 0x11..,0x22..,0x33..,0x44.. (64-bit repeats), then read 0x0000_0040 -> after READ_LATENCY, 4 rvalid beats in that order, raddr=0x0000_0040.
- Issue 5 reads back-to-back with QUEUE_DEPTH=4, READ_LATENCY=8 -> ready low on 5th request until first pop; 20 rvalid beats contiguous, addresses in issue order.
- Drop bmem_write after beat 1 -> bmem_err=1 stays set; read back shows new words 0,1 and old words 2,3.
- Assert read and write together on idle cycle -> write accepted, read accepted on cycle 5 if held; err=0.
- Address 0x0000_2040 with ADDR_LINES=256 -> aliases line 2 (0x40>>5 wraps); write one, read other returns same data.
- Assert rst mid read burst (after beat 1) -> rvalid=0 immediately, no beats 2..3, ready=1 one cycle after release, queue empty.
